// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  // Frame receive states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int unsigned PS2_DATA_BITS = 8;

  // statusFlags bit positions
  localparam int unsigned STAT_OVF_BIT = 0;
  localparam int unsigned STAT_ERR_BIT = 1;
  localparam int unsigned STAT_W       = 2;

endpackage

// File: rtl/scan_fifo.sv
// Synchronous scan-code FIFO. A pop on empty is ignored; a push on full
// only succeeds when a pop frees the head in the same cycle.
module scan_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PS2_DATA_BITS-1:0] wdata,
  output logic [PS2_DATA_BITS-1:0] head_c,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PS2_DATA_BITS-1:0] mem_q [DEPTH];
  logic [PS2_DATA_BITS-1:0] mem_d [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q,  count_d;
  logic                     do_push, do_pop;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));
  assign head_c  = empty_c ? '0 : mem_q[rd_ptr_q];

  // Resolve push/pop against occupancy and compute next pointers/storage
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty_c;
    do_push  = push && (!full_c || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = AW'(wr_ptr_q + AW'(1));
    end
    if (do_pop) begin
      rd_ptr_d = AW'(rd_ptr_q + AW'(1));
    end
    count_d = CW'(count_q + CW'(do_push) - CW'(do_pop));
  end

  // FIFO state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: deserialises device-to-host frames, checks
// framing and odd parity, buffers scan codes and raises a level interrupt.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [3:0]  INT_INDEX      = 4'h1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2Clk,
  input  logic               ps2Data,
  input  logic               intAck,
  output logic               hardwareInterruptSignal,
  output logic [3:0]         hardwareInterruptIndex,
  output logic [15:0]        keyboardData,
  output logic [STAT_W-1:0]  statusFlags
);

  localparam int unsigned CNT_W = $clog2(PS2_DATA_BITS);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Pin synchronisers and edge detector
  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic fall_q, fall_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d, dat_q, dat_d;

  // Receiver state
  ps2_state_e               state_q, state_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                     parity_q, parity_d;
  logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
  logic [STAT_W-1:0]        flags_q, flags_d;
  logic [3:0]               idx_q, idx_d;
  logic                     push_c, err_set_c, ovf_set_c;

  logic [PS2_DATA_BITS-1:0] head_c;
  logic                     full_c, empty_c;

  // Two-stage synchronisers; falling edge registered from the second stage
  always_comb begin
    clk_s1_d   = ps2Clk;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    fall_d     = clk_prev_q & ~clk_s2_q;
    dat_s1_d   = ps2Data;
    dat_s2_d   = dat_s1_q;
    dat_d      = dat_s2_q;
  end

  // Synchroniser and edge registers (pins idle high)
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      dat_q      <= 1'b1;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      fall_q     <= fall_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      dat_q      <= dat_d;
    end
  end

  // Frame FSM, timeout and sticky flags
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    flags_d   = flags_q;
    idx_d     = INT_INDEX;
    push_c    = 1'b0;
    err_set_c = 1'b0;

    if (fall_q || state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LAST) begin
      to_cnt_d = TO_W'(to_cnt_q + TO_W'(1));
    end else begin
      to_cnt_d = to_cnt_q;
    end

    unique case (state_q)
      IDLE: begin
        if (fall_q) begin
          if (!dat_q) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = DATA;
          end else begin
            err_set_c = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall_q) begin
          shift_d   = {dat_q, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = CNT_W'(bit_cnt_q + CNT_W'(1));
          if (bit_cnt_q == CNT_W'(PS2_DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall_q) begin
          parity_d = dat_q;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall_q) begin
          if (dat_q && (^{shift_q, parity_q})) begin
            push_c = 1'b1;
          end else begin
            err_set_c = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled partial frame is silently abandoned
    if (!fall_q && state_q != IDLE && to_cnt_q == TO_LAST) begin
      state_d = IDLE;
      shift_d = '0;
    end

    // Overflow only when the push cannot ride on a same-cycle pop
    ovf_set_c = push_c && full_c && !intAck;
    if (ovf_set_c) flags_d[STAT_OVF_BIT] = 1'b1;
    if (err_set_c) flags_d[STAT_ERR_BIT] = 1'b1;
  end

  // Receiver state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
      flags_q   <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
      flags_q   <= flags_d;
      idx_q     <= idx_d;
    end
  end

  scan_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (intAck),
    .wdata   (shift_q),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  assign hardwareInterruptSignal = !empty_c;
  assign hardwareInterruptIndex  = idx_q;
  assign keyboardData            = {8'h00, head_c};
  assign statusFlags             = flags_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard with a scan-code scoreboard queue.
module tb_ps2_keyboard;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 1000;
  localparam int          HALF    = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2Clk;
  logic        ps2Data;
  logic        intAck;
  logic        hardwareInterruptSignal;
  logic [3:0]  hardwareInterruptIndex;
  logic [15:0] keyboardData;
  logic [1:0]  statusFlags;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [1:0] exp_flags;

  ps2_keyboard #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT),
    .INT_INDEX      (4'h1)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .ps2Clk                  (ps2Clk),
    .ps2Data                 (ps2Data),
    .intAck                  (intAck),
    .hardwareInterruptSignal (hardwareInterruptSignal),
    .hardwareInterruptIndex  (hardwareInterruptIndex),
    .keyboardData            (keyboardData),
    .statusFlags             (statusFlags)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare interrupt and data word against the scoreboard head
  task automatic check_head(input string tag);
    logic [15:0] exp_data;
    exp_data = (exp_q.size() != 0) ? {8'h00, exp_q[0]} : 16'h0000;
    check({tag, ".int"}, 32'(hardwareInterruptSignal), 32'(exp_q.size() != 0));
    check({tag, ".data"}, 32'(keyboardData), 32'(exp_data));
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".flags"}, 32'(statusFlags), 32'(exp_flags));
  endtask

  task automatic model_push(input logic [7:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_flags[0] = 1'b1;
  endtask

  // One PS/2 bit; optionally pulse intAck in the cycle the falling edge is registered
  task automatic send_bit(input logic b, input logic ack_at_edge);
    ps2Data = b;
    tick(HALF);
    ps2Clk = 1'b0;
    if (ack_at_edge) begin
      tick(3);
      intAck = 1'b1;
      tick(1);
      intAck = 1'b0;
      tick(HALF - 4);
    end else begin
      tick(HALF);
    end
    ps2Clk = 1'b1;
  endtask

  // Send frame bits [first..last] of an 11-bit frame (start, 8 data, parity, stop)
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input int first,
                            input int last, input logic ack_stop);
    logic [10:0] bits;
    bits = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = first; i <= last; i++) begin
      send_bit(bits[i], ack_stop && (i == 10));
    end
    tick(HALF);
  endtask

  task automatic ack();
    intAck = 1'b1;
    tick(1);
    intAck = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  initial begin
    rst       = 1'b0;
    ps2Clk    = 1'b1;
    ps2Data   = 1'b1;
    intAck    = 1'b0;
    exp_flags = 2'b00;

    // Reset state
    tick(3);
    check("rst.idx", 32'(hardwareInterruptIndex), 32'h0);
    check_head("rst");
    check_flags("rst");
    rst = 1'b1;
    tick(2);
    check("run.idx", 32'(hardwareInterruptIndex), 32'h1);

    // Single valid frame, then acknowledge
    send_frame(8'h1C, 1'b0, 0, 10, 1'b0);
    model_push(8'h1C);
    check_head("t1");
    check("t1.kbd", 32'(keyboardData), 32'h001C);
    ack();
    check_head("t1.ack");

    // Wrong parity: dropped, error flag set
    send_frame(8'hF0, 1'b1, 0, 10, 1'b0);
    exp_flags[1] = 1'b1;
    check_head("t2");
    check_flags("t2");

    // Overflow: five frames into a four-entry buffer
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b0, 0, 10, 1'b0);
      model_push(8'(i));
    end
    check_flags("t3");
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("t3.drain%0d", i));
      ack();
    end
    check_head("t3.empty");
    ack();
    check_head("t3.ackempty");

    // Full buffer: stop-bit push coincides with intAck
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b0, 0, 10, 1'b0);
      model_push(8'(i));
    end
    send_frame(8'h06, 1'b0, 0, 10, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h06);
    check_head("t4");
    check_flags("t4");
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("t4.drain%0d", i));
      ack();
    end
    check_head("t4.empty");

    // Stalled frame after four data bits is abandoned
    send_frame(8'hA5, 1'b0, 0, 4, 1'b0);
    tick(TIMEOUT + 200);
    send_frame(8'h29, 1'b0, 0, 10, 1'b0);
    model_push(8'h29);
    check_head("t5");
    check_flags("t5");
    ack();
    check_head("t5.ack");

    // Reset mid-frame with two bytes buffered
    send_frame(8'h11, 1'b0, 0, 10, 1'b0);
    model_push(8'h11);
    send_frame(8'h22, 1'b0, 0, 10, 1'b0);
    model_push(8'h22);
    check_head("t6.pre");
    send_frame(8'h33, 1'b0, 0, 4, 1'b0);
    rst = 1'b0;
    tick(1);
    exp_q.delete();
    exp_flags = 2'b00;
    check("t6.rst.idx", 32'(hardwareInterruptIndex), 32'h0);
    check_head("t6.rst");
    check_flags("t6.rst");
    rst = 1'b1;
    send_frame(8'h33, 1'b0, 5, 10, 1'b0);
    tick(TIMEOUT + 200);
    check_head("t6.rest");
    send_frame(8'h5A, 1'b0, 0, 10, 1'b0);
    model_push(8'h5A);
    check_head("t6.5a");
    check("t6.idx", 32'(hardwareInterruptIndex), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
